// File: rtl/multi_command_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : multi_command_unit                                              |
// | Purpose  : Round-robin command receiver. Arbitrates NUM_CH AXI4-Stream     |
// |            command pipes onto one registered valid/ready output tagged     |
// |            with the source channel; ends when all channels send FINISH.    |
// | Options  : CMD_TIMEOUT_EN - builds the idle watchdog (TIMEOUT_CYCLES).     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module multi_command_unit #(
   parameter int NUM_CH         = 4,
   parameter int DATA_W         = 32,
   parameter int CMD_W          = 4,
   parameter int TIMEOUT_CYCLES = 65536,
   localparam int CH_W          = $clog2(NUM_CH)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   output logic                     done,
   input  logic [NUM_CH*DATA_W-1:0] pipe_tdata,
   input  logic [NUM_CH-1:0]        pipe_tvalid,
   output logic [NUM_CH-1:0]        pipe_tready,
   output logic [CMD_W-1:0]         cmd,
   output logic [CH_W-1:0]          cmd_ch,
   output logic                     cmd_valid,
   input  logic                     cmd_ready,
   output logic                     proto_err,
   output logic                     timeout
);

   localparam logic [CMD_W-1:0]  c_comm_nop    = '0;
   localparam logic [CMD_W-1:0]  c_comm_finish = '1;
   localparam logic [NUM_CH-1:0] c_all_fin     = '1;
   localparam logic [CH_W-1:0]   c_rr_init     = CH_W'(NUM_CH - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [NUM_CH-1:0]   r_fin_mask;
   logic [NUM_CH-1:0]   w_fin_mask_next;
   logic [CH_W-1:0]     r_rr;
   logic [CMD_W-1:0]    r_cmd;
   logic [CH_W-1:0]     r_cmd_ch;
   logic                r_cmd_valid;
   logic                r_proto_err;
   logic                r_timeout;

   logic [CMD_W-1:0]    w_ch_cmd [NUM_CH];
   logic [NUM_CH-1:0]   w_eligible;
   logic                w_grant_found;
   logic [CH_W-1:0]     w_grant_idx;
   logic [NUM_CH-1:0]   w_grant_onehot;
   logic [CMD_W-1:0]    w_grant_cmd;
   logic                w_free;
   logic                w_accept;
   logic                w_load;
   logic                w_sink_hit;
   logic                w_wd_fire;

   // Command field of each channel; upper data bits carry no meaning here.
   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign w_ch_cmd[gi] = pipe_tdata[gi*DATA_W +: CMD_W];
   end

   assign w_eligible     = pipe_tvalid & ~r_fin_mask;
   assign w_free         = !r_cmd_valid || cmd_ready;
   assign w_grant_cmd    = w_ch_cmd[w_grant_idx];
   assign w_grant_onehot = {{(NUM_CH-1){1'b0}}, 1'b1} << w_grant_idx;
   assign w_accept       = (r_state == S_RUN) && w_free && w_grant_found;
   assign w_load         = w_accept && (w_grant_cmd != c_comm_nop);
   assign w_sink_hit     = (r_state == S_RUN) && (|(pipe_tvalid & r_fin_mask));

   // Round-robin search from rr+1; scanning far-to-near lets the nearest win.
   always_comb begin
      int v_idx;
      v_idx         = 0;
      w_grant_found = 1'b0;
      w_grant_idx   = '0;
      for (int k = NUM_CH; k >= 1; k--) begin
         v_idx = (int'(r_rr) + k) % NUM_CH;
         if (w_eligible[v_idx[CH_W-1:0]]) begin
            w_grant_found = 1'b1;
            w_grant_idx   = v_idx[CH_W-1:0];
         end
      end
   end

   // Finish mask seen by the next cycle: accepted FINISH or watchdog expiry.
   always_comb begin
      w_fin_mask_next = r_fin_mask;
      if (w_accept && (w_grant_cmd == c_comm_finish)) begin
         w_fin_mask_next = w_fin_mask_next | w_grant_onehot;
      end
      if (w_wd_fire) begin
         w_fin_mask_next = c_all_fin;
      end
   end

`ifdef CMD_TIMEOUT_EN
   localparam int c_wd_w = $clog2(TIMEOUT_CYCLES + 1);
   logic [c_wd_w-1:0] r_wd_cnt;

   // Idle watchdog: counts RUN cycles without any accepted word.
   always_ff @(posedge clk) begin
      if (!rst_n || (r_state != S_RUN) || w_accept || w_sink_hit) begin
         r_wd_cnt <= '0;
      end else begin
         r_wd_cnt <= r_wd_cnt + 1'b1;
      end
   end

   assign w_wd_fire = (r_state == S_RUN) && !w_accept && !w_sink_hit &&
                      (r_wd_cnt == c_wd_w'(TIMEOUT_CYCLES - 1));
`else
   assign w_wd_fire = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state and per-channel ready; finished channels always sink words.
   always_comb begin
      w_state_next = r_state;
      pipe_tready  = '0;
      case (r_state)
         S_IDLE: begin
            if (start) w_state_next = S_RUN;
         end
         S_RUN: begin
            pipe_tready = r_fin_mask;
            if (w_free && w_grant_found) pipe_tready[w_grant_idx] = 1'b1;
            if (w_fin_mask_next == c_all_fin) w_state_next = S_DRAIN;
         end
         S_DRAIN: begin
            if (!r_cmd_valid || cmd_ready) w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // Datapath: output slot, finish tracking, rr pointer and sticky flags.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_fin_mask  <= '0;
         r_rr        <= c_rr_init;
         r_cmd       <= '0;
         r_cmd_ch    <= '0;
         r_cmd_valid <= 1'b0;
         r_proto_err <= 1'b0;
         r_timeout   <= 1'b0;
      end else begin
         if ((r_state == S_IDLE) && start) begin
            r_fin_mask  <= '0;
            r_rr        <= c_rr_init;
            r_proto_err <= 1'b0;
            r_timeout   <= 1'b0;
         end else begin
            r_fin_mask <= w_fin_mask_next;
            if (w_accept)   r_rr        <= w_grant_idx;
            if (w_sink_hit) r_proto_err <= 1'b1;
            if (w_wd_fire)  r_timeout   <= 1'b1;
         end
         if (w_load) begin
            r_cmd       <= w_grant_cmd;
            r_cmd_ch    <= w_grant_idx;
            r_cmd_valid <= 1'b1;
         end else if (r_cmd_valid && cmd_ready) begin
            r_cmd_valid <= 1'b0;
         end
      end
   end

   assign done      = (r_state == S_IDLE);
   assign cmd       = r_cmd;
   assign cmd_ch    = r_cmd_ch;
   assign cmd_valid = r_cmd_valid;
   assign proto_err = r_proto_err;
   assign timeout   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_multi_command_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_multi_command_unit                                           |
// | Purpose  : Self-checking bench for multi_command_unit: vector table of     |
// |            single-word sends plus hand-written multi-cycle sequences, with |
// |            a queue scoreboard of expected output beats.                    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_multi_command_unit;

   localparam int NUM_CH = 4;
   localparam int DATA_W = 32;
   localparam int CMD_W  = 4;
   localparam int CH_W   = 2;

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic                     start;
   logic                     done;
   logic [NUM_CH*DATA_W-1:0] pipe_tdata;
   logic [NUM_CH-1:0]        pipe_tvalid;
   logic [NUM_CH-1:0]        pipe_tready;
   logic [CMD_W-1:0]         cmd;
   logic [CH_W-1:0]          cmd_ch;
   logic                     cmd_valid;
   logic                     cmd_ready;
   logic                     proto_err;
   logic                     timeout;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [CMD_W-1:0] cmd;
      logic [CH_W-1:0]  ch;
   } beat_t;
   beat_t exp_q[$];

   typedef struct {
      int          ch;
      logic [31:0] word;
      logic        fwd;
      logic        exp_proto;
   } vec_t;

   multi_command_unit #(
      .NUM_CH(NUM_CH), .DATA_W(DATA_W), .CMD_W(CMD_W), .TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .done(done),
      .pipe_tdata(pipe_tdata), .pipe_tvalid(pipe_tvalid), .pipe_tready(pipe_tready),
      .cmd(cmd), .cmd_ch(cmd_ch), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .proto_err(proto_err), .timeout(timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: every output handshake must match the oldest expected beat.
   always @(negedge clk) begin
      if (rst_n && cmd_valid && cmd_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_beat", {26'd0, cmd_ch, cmd}, 32'hFFFF_FFFF);
         end else begin
            beat_t e;
            e = exp_q.pop_front();
            chk("beat", {26'd0, cmd_ch, cmd}, {26'd0, e.ch, e.cmd});
         end
      end
   end

   task automatic do_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic push(input logic [3:0] c, input int ch);
      beat_t b;
      b.cmd = c;
      b.ch  = ch[CH_W-1:0];
      exp_q.push_back(b);
   endtask

   // Present one word on a channel until it is taken (bounded).
   task automatic send(input int ch, input logic [31:0] word);
      int n;
      n = 0;
      pipe_tvalid[ch] = 1'b1;
      pipe_tdata[ch*DATA_W +: DATA_W] = word;
      do begin
         @(negedge clk);
         n++;
      end while (!pipe_tready[ch] && n < 20);
      if (!pipe_tready[ch]) chk("handshake_timeout", 32'd0, 32'd1);
      @(posedge clk); #1 pipe_tvalid[ch] = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (!done && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk(name, {31'd0, done}, 32'd1);
      @(posedge clk); #1;
   endtask

   initial begin
      vec_t             vt[7];
      logic [NUM_CH-1:0] rr_exp[5];

      vt[0] = '{0, 32'h0000_0003, 1'b1, 1'b0};
      vt[1] = '{2, 32'hA5A5_A009, 1'b1, 1'b0};
      vt[2] = '{0, 32'h0000_0000, 1'b0, 1'b0};
      vt[3] = '{1, 32'h0000_000F, 1'b1, 1'b0};
      vt[4] = '{1, 32'h0000_0007, 1'b0, 1'b1};
      vt[5] = '{3, 32'h1234_5670, 1'b0, 1'b1};
      vt[6] = '{3, 32'h0000_000C, 1'b1, 1'b1};
      rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
      rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;

      rst_n = 1'b0; start = 1'b1; cmd_ready = 1'b1;
      pipe_tvalid = '0; pipe_tdata = '0;

      // Reset with start held: reset wins and outputs take reset values.
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1; start = 1'b0;
      @(negedge clk);
      chk("rst_done", {31'd0, done}, 32'd1);
      chk("rst_tready", {28'd0, pipe_tready}, 32'd0);
      chk("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
      chk("rst_cmd", {26'd0, cmd_ch, cmd}, 32'd0);
      chk("rst_flags", {30'd0, proto_err, timeout}, 32'd0);
      repeat (2) @(negedge clk);
      chk("rst_start_ignored", {31'd0, done}, 32'd1);

      // Sequence A: ch0 0x3,0xF; ch1..3 0xF; last FINISH waits in DRAIN.
      do_start();
      chk("a_running", {31'd0, done}, 32'd0);
      push(4'h3, 0); send(0, 32'h3);
      push(4'hF, 0); send(0, 32'hF);
      push(4'hF, 1); send(1, 32'hF);
      push(4'hF, 2); send(2, 32'hF);
      @(posedge clk); #1 cmd_ready = 1'b0;
      push(4'hF, 3); send(3, 32'hF);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("a_drain_hold", {24'd0, done, pipe_tready, cmd_valid, cmd_ch, cmd}, {24'd0, 1'b0, 4'b0000, 1'b1, 2'd3, 4'hF});
      end
      @(posedge clk); #1 cmd_ready = 1'b1;
      @(negedge clk);
      chk("a_done_during_beat", {31'd0, done}, 32'd0);
      @(negedge clk);
      chk("a_done_after_beat", {31'd0, done}, 32'd1);

      // Sequence B: all channels valid with 0x5, one beat per cycle.
      do_start();
      pipe_tdata = {4{32'h0000_0005}};
      pipe_tvalid = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         push(4'h5, i % 4);
         @(negedge clk);
         chk("b_rr_grant", {28'd0, pipe_tready}, {28'd0, rr_exp[i]});
         if (i > 0) chk("b_throughput", {31'd0, cmd_valid}, 32'd1);
         @(posedge clk); #1;
      end
      pipe_tvalid = '0;
      @(negedge clk);
      chk("b_last_beat", {31'd0, cmd_valid}, 32'd1);
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
         push(4'hF, i); send(i, 32'hF);
      end
      wait_done("b_done");

      // Sequence C: backpressure on ch2, then release; reset with a pending cmd.
      do_start();
      cmd_ready = 1'b0;
      push(4'h6, 2); send(2, 32'h6);
      push(4'h8, 2);
      pipe_tdata[2*DATA_W +: DATA_W] = 32'h8;
      pipe_tvalid[2] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("c_stall", {24'd0, pipe_tready, cmd_valid, cmd_ch, cmd}, {24'd0, 4'b0000, 1'b1, 2'd2, 4'h6});
         @(posedge clk); #1;
      end
      cmd_ready = 1'b1;
      @(negedge clk);
      chk("c_release_tready", {28'd0, pipe_tready}, 32'b0100);
      @(posedge clk); #1 pipe_tvalid[2] = 1'b0;
      @(posedge clk); #1 cmd_ready = 1'b0;
      send(1, 32'h4);
      #1 rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("c_reset_discard", {30'd0, done, cmd_valid}, 32'b10);
      cmd_ready = 1'b1;

      // Vector table: single-word sends, NOP, upper bits, finished-channel drops.
      do_start();
      for (int i = 0; i < 7; i++) begin
         if (vt[i].fwd) push(vt[i].word[3:0], vt[i].ch);
         send(vt[i].ch, vt[i].word);
         repeat (2) @(posedge clk);
         #1;
         chk("vec_proto_err", {31'd0, proto_err}, {31'd0, vt[i].exp_proto});
         chk("vec_drained", exp_q.size(), 32'd0);
      end
      push(4'hF, 0); send(0, 32'hF);
      push(4'hF, 2); send(2, 32'hF);
      push(4'hF, 3); send(3, 32'hF);
      wait_done("vec_done");

      // NOP on ch0 must not be forwarded but must still move rr to 0.
      do_start();
      send(0, 32'h0);
      @(negedge clk);
      chk("nop_no_valid", {31'd0, cmd_valid}, 32'd0);
      @(posedge clk); #1;
      pipe_tdata = {4{32'h0000_0002}};
      pipe_tvalid = 4'b1111;
      @(negedge clk);
      chk("nop_rr_next", {28'd0, pipe_tready}, 32'b0010);
      pipe_tvalid = '0;
      @(posedge clk); #1 rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;

      // Idle watchdog: no traffic after start.
      do_start();
      repeat (16) @(posedge clk);
      @(negedge clk);
`ifdef CMD_TIMEOUT_EN
      chk("wd_cycle17", {30'd0, timeout, done}, 32'b10);
      @(negedge clk);
      chk("wd_cycle18", {30'd0, timeout, done}, 32'b11);
`else
      chk("wd_cycle17", {30'd0, timeout, done}, 32'b00);
      repeat (10) @(negedge clk);
      chk("wd_no_timeout", {30'd0, timeout, done}, 32'b00);
`endif
      @(posedge clk); #1 rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;

      @(negedge clk);
      chk("final_queue_empty", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
